// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo
// ----------------------------------------------------------------------------
// Oversampling UART receiver with a small character FIFO on its output.
//
// Each character is received in this order: falling-edge start detection,
// a glitch check at mid start bit, 5..8 data bits (LSB first), an optional
// odd/even parity bit, and 1 or 2 stop bits. It is then pushed into the FIFO
// together with its parity-error, framing-error and break flags. The consumer
// reads the FIFO head through a valid/ready handshake.
//
// Optional build macro:
//   RX_MAJORITY_VOTE_EN - each bit is the 2-of-3 majority of three
//                         consecutive ticks centred on mid-bit, instead of a
//                         single mid-bit sample.
//
// Parameters:
//   MAX_UART_DATA_W  rx_data_o width (>= 8); bits above 7 read 0
//   OVERSAMPLE       baud_en_i ticks per bit (even, 8..32)
//   FIFO_DEPTH       character entries (power of two, >= 2)
//   TOTAL_CONF_WIDTH conf = {data_sel[1:0], stop2, parity_odd, parity_en}
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   baud_en_i        oversample tick, one clk wide
//   rx_en_i          receiver enable (0 aborts a frame in progress)
//   uart_rx_i        synchronised Rx line, idle high
//   rx_conf_i        frame format, latched at each start bit
//   rx_ready_i       consumer ready; pop on rx_valid_o & rx_ready_i
//   rx_clr_i         clears rx_overrun_o
//   rx_valid_o       FIFO head valid
//   rx_data_o        head character
//   rx_parity_err_o  head character parity error
//   rx_frame_err_o   head character had a stop bit sampled 0
//   rx_break_o       head character is a break condition
//   rx_busy_o        receiver FSM is not idle
//   rx_overrun_o     sticky: a character was dropped because the FIFO was full
//   rx_level_o       FIFO occupancy, 0..FIFO_DEPTH
// ============================================================================
module uart_rx_fifo #(
    parameter int MAX_UART_DATA_W  = 8,
    parameter int OVERSAMPLE       = 16,
    parameter int FIFO_DEPTH       = 4,
    parameter int TOTAL_CONF_WIDTH = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          baud_en_i,
    input  logic                          rx_en_i,
    input  logic                          uart_rx_i,
    input  logic [TOTAL_CONF_WIDTH-1:0]   rx_conf_i,
    input  logic                          rx_ready_i,
    input  logic                          rx_clr_i,
    output logic                          rx_valid_o,
    output logic [MAX_UART_DATA_W-1:0]    rx_data_o,
    output logic                          rx_parity_err_o,
    output logic                          rx_frame_err_o,
    output logic                          rx_break_o,
    output logic                          rx_busy_o,
    output logic                          rx_overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);

`ifdef RX_MAJORITY_VOTE_EN
    // The vote needs the tick after the nominal sample point, so every
    // decision lands one tick later. The start decision tick stands in for
    // count 0 of the first data bit, hence the data counter restarts at 1.
    localparam logic [CNT_W-1:0] START_CNT     = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] SAMPLE_CNT    = '0;
    localparam logic [CNT_W-1:0] DATA_CNT_INIT = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] START_CNT     = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] SAMPLE_CNT    = CNT_MAX;
    localparam logic [CNT_W-1:0] DATA_CNT_INIT = '0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_PUSH
    } state_t;

    typedef struct packed {
        logic       brk;
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } entry_t;

    // ------------------------------------------------------------------------
    // Bit value at the sample point
    // ------------------------------------------------------------------------
    logic bit_val;

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;     // line on the previous two ticks, [1] is older

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= 2'b11;
        end else if (baud_en_i) begin
            hist_q <= {hist_q[0], uart_rx_i};
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) |
                     (hist_q[1] & uart_rx_i) |
                     (hist_q[0] & uart_rx_i);
`else
    assign bit_val = uart_rx_i;
`endif

    // ------------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------------
    state_t                      state_q;
    logic                        busy_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [2:0]                  bit_cnt_q;
    logic [7:0]                  data_q;
    logic [TOTAL_CONF_WIDTH-1:0] conf_q;
    logic                        par_bit_q;
    logic                        par_err_q;
    logic                        frame_err_q;

    logic                        parity_en;
    logic                        parity_odd;
    logic                        stop2;
    logic [2:0]                  last_bit;
    logic [CNT_W-1:0]            cnt_wrap;

    assign parity_en  = conf_q[0];
    assign parity_odd = conf_q[1];
    assign stop2      = conf_q[2];
    assign last_bit   = 3'd4 + {1'b0, conf_q[4:3]};
    assign cnt_wrap   = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            conf_q      <= '0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (baud_en_i && rx_en_i && !uart_rx_i) begin
                        state_q     <= ST_START;
                        busy_q      <= 1'b1;
                        conf_q      <= rx_conf_i;
                        cnt_q       <= '0;
                        bit_cnt_q   <= '0;
                        data_q      <= '0;
                        par_bit_q   <= 1'b0;
                        par_err_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                    end
                end

                // One clk regardless of ticks; the FIFO side consumes the
                // entry during this cycle.
                ST_PUSH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    if (baud_en_i) begin
                        if (!rx_en_i) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_wrap;
                            case (state_q)
                                ST_START: begin
                                    if (cnt_q == START_CNT) begin
                                        if (bit_val) begin
                                            state_q <= ST_IDLE;     // glitch
                                            busy_q  <= 1'b0;
                                        end else begin
                                            state_q <= ST_DATA;
                                            cnt_q   <= DATA_CNT_INIT;
                                        end
                                    end
                                end
                                ST_DATA: begin
                                    if (cnt_q == SAMPLE_CNT) begin
                                        data_q[bit_cnt_q] <= bit_val;
                                        if (bit_cnt_q == last_bit) begin
                                            bit_cnt_q <= '0;
                                            state_q   <= parity_en ? ST_PARITY : ST_STOP;
                                        end else begin
                                            bit_cnt_q <= bit_cnt_q + 3'd1;
                                        end
                                    end
                                end
                                ST_PARITY: begin
                                    if (cnt_q == SAMPLE_CNT) begin
                                        par_bit_q <= bit_val;
                                        par_err_q <= bit_val != (^data_q ^ parity_odd);
                                        state_q   <= ST_STOP;
                                    end
                                end
                                ST_STOP: begin
                                    if (cnt_q == SAMPLE_CNT) begin
                                        if (!bit_val) begin
                                            frame_err_q <= 1'b1;
                                        end
                                        // Leave on the last stop sample so a
                                        // start edge right after it is seen.
                                        if (stop2 && bit_cnt_q == 3'd0) begin
                                            bit_cnt_q <= 3'd1;
                                        end else begin
                                            state_q <= ST_PUSH;
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign rx_busy_o = busy_q;

    // ------------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------------
    entry_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overrun_q, overrun_d;

    logic               head_valid_q;
    logic [MAX_UART_DATA_W-1:0] head_data_q;
    logic               head_perr_q;
    logic               head_ferr_q;
    logic               head_brk_q;

    logic               push_req;
    logic               full;
    logic               pop;
    logic               push;
    entry_t             push_entry;
    entry_t             rd_entry;

    assign push_req = (state_q == ST_PUSH);
    assign full     = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop      = head_valid_q & rx_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = push_req & (~full | pop);

    assign push_entry.brk        = (data_q == 8'h00) && (!parity_en || !par_bit_q) && frame_err_q;
    assign push_entry.frame_err  = frame_err_q;
    assign push_entry.parity_err = par_err_q;
    assign push_entry.data       = data_q;

    assign wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
    // A new drop wins over a simultaneous clear.
    assign overrun_d = (push_req & full & ~pop) ? 1'b1 :
                       (rx_clr_i ? 1'b0 : overrun_q);

    // Next head entry. When the FIFO goes to exactly one entry with a push,
    // that entry is the one being written this cycle and is not in mem_q yet.
    always_comb begin
        rd_entry = mem_q[rd_ptr_d];
        if (push && (rd_ptr_d == wr_ptr_q)) begin
            rd_entry = push_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overrun_q    <= 1'b0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            head_perr_q  <= 1'b0;
            head_ferr_q  <= 1'b0;
            head_brk_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overrun_q    <= overrun_d;
            head_valid_q <= (level_d != '0);
            if (level_d != '0) begin
                head_data_q <= MAX_UART_DATA_W'(rd_entry.data);
                head_perr_q <= rd_entry.parity_err;
                head_ferr_q <= rd_entry.frame_err;
                head_brk_q  <= rd_entry.brk;
            end else begin
                head_data_q <= '0;
                head_perr_q <= 1'b0;
                head_ferr_q <= 1'b0;
                head_brk_q  <= 1'b0;
            end
        end
    end

    assign rx_valid_o      = head_valid_q;
    assign rx_data_o       = head_data_q;
    assign rx_parity_err_o = head_perr_q;
    assign rx_frame_err_o  = head_ferr_q;
    assign rx_break_o      = head_brk_q;
    assign rx_overrun_o    = overrun_q;
    assign rx_level_o      = level_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// tb_uart_rx_fifo
// ----------------------------------------------------------------------------
// Serialises characters onto the Rx line and compares what the receiver
// hands out against a queue of expected characters computed from the frame
// rules (masking, parity sums, stop-bit values) and a depth-limited FIFO.
// ============================================================================
module tb_uart_rx_fifo;

    localparam int OS       = 16;
    localparam int DEPTH    = 4;
    localparam int W        = 8;
    localparam int BIT_CLKS = OS * 4;   // baud_en_i every 4 clk

    logic            clk_i      = 1'b0;
    logic            rst_ni     = 1'b0;
    logic            baud_en_i  = 1'b0;
    logic            rx_en_i    = 1'b0;
    logic            uart_rx_i  = 1'b1;
    logic [4:0]      rx_conf_i  = 5'b11000;
    logic            rx_ready_i = 1'b0;
    logic            rx_clr_i   = 1'b0;
    logic            rx_valid_o;
    logic [W-1:0]    rx_data_o;
    logic            rx_parity_err_o;
    logic            rx_frame_err_o;
    logic            rx_break_o;
    logic            rx_busy_o;
    logic            rx_overrun_o;
    logic [2:0]      rx_level_o;

    uart_rx_fifo #(
        .MAX_UART_DATA_W  (W),
        .OVERSAMPLE       (OS),
        .FIFO_DEPTH       (DEPTH),
        .TOTAL_CONF_WIDTH (5)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .baud_en_i       (baud_en_i),
        .rx_en_i         (rx_en_i),
        .uart_rx_i       (uart_rx_i),
        .rx_conf_i       (rx_conf_i),
        .rx_ready_i      (rx_ready_i),
        .rx_clr_i        (rx_clr_i),
        .rx_valid_o      (rx_valid_o),
        .rx_data_o       (rx_data_o),
        .rx_parity_err_o (rx_parity_err_o),
        .rx_frame_err_o  (rx_frame_err_o),
        .rx_break_o      (rx_break_o),
        .rx_busy_o       (rx_busy_o),
        .rx_overrun_o    (rx_overrun_o),
        .rx_level_o      (rx_level_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned tick_div = 0;
    always @(negedge clk_i) begin
        tick_div  = (tick_div + 1) % 4;
        baud_en_i = (tick_div == 0);
    end

    // ------------------------------------------------------------------------
    // Checking and reference model
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    exp_t model_q[$];
    logic model_ovr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic good_parity(input logic [4:0] conf, input logic [7:0] data);
        int nb = 5 + int'(conf[4:3]);
        int d  = int'(data) % (1 << nb);
        return logic'(($countones(d) + int'(conf[1])) % 2);
    endfunction

    task automatic model_rx(input logic [4:0] conf, input logic [7:0] data,
                            input logic par_bit, input logic s1, input logic s2);
        exp_t e;
        int nb = 5 + int'(conf[4:3]);
        int d  = int'(data) % (1 << nb);
        e.data = 8'(d);
        e.perr = conf[0] && (par_bit != good_parity(conf, data));
        e.ferr = (s1 == 1'b0) || (conf[2] && s2 == 1'b0);
        e.brk  = (d == 0) && (!conf[0] || par_bit == 1'b0) && e.ferr;
        if (model_q.size() < DEPTH) model_q.push_back(e);
        else model_ovr = 1'b1;
    endtask

    task automatic hold_bit(input logic v);
        uart_rx_i = v;
        repeat (BIT_CLKS) @(negedge clk_i);
    endtask

    // Send a frame, record the expected outcome, leave two idle bit times.
    task automatic tx(input logic [4:0] conf, input logic [7:0] data,
                      input logic par_bit, input logic s1, input logic s2);
        int nb = 5 + int'(conf[4:3]);
        model_rx(conf, data, par_bit, s1, s2);
        rx_conf_i = conf;
        hold_bit(1'b0);
        for (int i = 0; i < nb; i++) hold_bit(data[i]);
        if (conf[0]) hold_bit(par_bit);
        hold_bit(s1);
        if (conf[2]) hold_bit(s2);
        hold_bit(1'b1);
        hold_bit(1'b1);
        $display("[TB] tx conf=%05b data=0x%02h par=%0d stop=%0d%0d", conf, data, par_bit, s1, s2);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_level"},   32'(rx_level_o),   32'(model_q.size()));
        check_eq({tag, "_valid"},   32'(rx_valid_o),   32'(model_q.size() != 0));
        check_eq({tag, "_overrun"}, 32'(rx_overrun_o), 32'(model_ovr));
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        int   waited = 0;
        while (!rx_valid_o && waited < 400) begin
            @(negedge clk_i);
            waited++;
        end
        check_eq({tag, "_pop_valid"}, 32'(rx_valid_o), 32'd1);
        e = model_q.pop_front();
        check_eq({tag, "_data"}, 32'(rx_data_o),       32'(e.data));
        check_eq({tag, "_perr"}, 32'(rx_parity_err_o), 32'(e.perr));
        check_eq({tag, "_ferr"}, 32'(rx_frame_err_o),  32'(e.ferr));
        check_eq({tag, "_brk"},  32'(rx_break_o),      32'(e.brk));
        $display("[TB] %s pop data=0x%02h perr=%0d ferr=%0d brk=%0d", tag,
                 rx_data_o, rx_parity_err_o, rx_frame_err_o, rx_break_o);
        rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
    endtask

    task automatic pulse_clr();
        rx_clr_i = 1'b1;
        @(negedge clk_i);
        rx_clr_i  = 1'b0;
        model_ovr = 1'b0;
    endtask

`ifdef RX_MAJORITY_VOTE_EN
    // 8N1 frame with a one-tick inverted spike at the middle of each data bit.
    task automatic tx_spiky(input logic [7:0] data);
        model_rx(5'b11000, data, 1'b0, 1'b1, 1'b1);
        rx_conf_i = 5'b11000;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = data[i];
            repeat (BIT_CLKS / 2 - 2) @(negedge clk_i);
            uart_rx_i = ~data[i];
            repeat (4) @(negedge clk_i);
            uart_rx_i = data[i];
            repeat (BIT_CLKS / 2 - 2) @(negedge clk_i);
        end
        hold_bit(1'b1);
        hold_bit(1'b1);
        hold_bit(1'b1);
        $display("[TB] tx spiky data=0x%02h", data);
    endtask
`endif

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        repeat (95000) @(posedge clk_i);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [7:0] v;
        logic [4:0] conf;
        logic [7:0] data;
        logic       par;
        int         nfr;

        rx_en_i = 1'b1;
        repeat (5) @(negedge clk_i);

        // Reset state
        check_eq("rst_valid", 32'(rx_valid_o),      32'd0);
        check_eq("rst_data",  32'(rx_data_o),       32'd0);
        check_eq("rst_perr",  32'(rx_parity_err_o), 32'd0);
        check_eq("rst_ferr",  32'(rx_frame_err_o),  32'd0);
        check_eq("rst_brk",   32'(rx_break_o),      32'd0);
        check_eq("rst_busy",  32'(rx_busy_o),       32'd0);
        check_eq("rst_ovr",   32'(rx_overrun_o),    32'd0);
        check_eq("rst_level", 32'(rx_level_o),      32'd0);
        rst_ni = 1'b1;
        repeat (BIT_CLKS) @(negedge clk_i);

        // Nominal 8N1
        tx(5'b11000, 8'hA5, 1'b0, 1'b1, 1'b1);
        check_state("8n1");
        pop_and_check("8n1");
        check_state("8n1_drained");

        // 7E1 with wrong and correct parity bit
        tx(5'b10001, 8'h35, 1'b1, 1'b1, 1'b1);
        pop_and_check("7e1_bad");
        tx(5'b10001, 8'h35, 1'b0, 1'b1, 1'b1);
        pop_and_check("7e1_good");

        // Framing error and break
        tx(5'b11000, 8'h3C, 1'b0, 1'b0, 1'b1);
        pop_and_check("frame");
        tx(5'b11000, 8'h00, 1'b0, 1'b0, 1'b1);
        pop_and_check("break");
        check_state("break_drained");

        // Glitch: 3-tick low pulse on the idle line
        uart_rx_i = 1'b0;
        repeat (12) @(negedge clk_i);
        uart_rx_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check_eq("glitch_busy_during", 32'(rx_busy_o), 32'd1);
        repeat (2 * BIT_CLKS) @(negedge clk_i);
        check_eq("glitch_busy_after", 32'(rx_busy_o), 32'd0);
        check_state("glitch");

        // Overrun: five characters into a four-entry FIFO
        for (int i = 1; i <= 5; i++) tx(5'b11000, 8'(i), 1'b0, 1'b1, 1'b1);
        check_state("ovr_full");
        for (int i = 1; i <= 4; i++) pop_and_check("ovr");
        check_state("ovr_sticky");
        pulse_clr();
        check_state("ovr_cleared");

        // Reset in the middle of a frame with a character already queued
        tx(5'b11000, 8'h77, 1'b0, 1'b1, 1'b1);
        v = 8'h5A;
        rx_conf_i = 5'b11000;
        hold_bit(1'b0);
        for (int i = 0; i < 3; i++) hold_bit(v[i]);
        repeat (20) @(negedge clk_i);
        check_eq("midrst_busy_before", 32'(rx_busy_o), 32'd1);
        #3 rst_ni = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(rx_valid_o), 32'd0);
        check_eq("midrst_level", 32'(rx_level_o), 32'd0);
        check_eq("midrst_busy",  32'(rx_busy_o),  32'd0);
        check_eq("midrst_data",  32'(rx_data_o),  32'd0);
        @(negedge clk_i);
        uart_rx_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        model_q.delete();
        model_ovr = 1'b0;
        hold_bit(1'b1);
        tx(5'b11000, 8'h5A, 1'b0, 1'b1, 1'b1);
        check_state("after_rst");
        pop_and_check("after_rst");

`ifdef RX_MAJORITY_VOTE_EN
        tx_spiky(8'h96);
        pop_and_check("vote");
`endif

        // Randomised rounds: random formats, corrupted parity and stop bits,
        // bursts that may overflow the FIFO.
        for (int r = 0; r < 10; r++) begin
            nfr = int'($urandom_range(1, 5));
            for (int k = 0; k < nfr; k++) begin
                conf = 5'($urandom);
                data = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                par  = good_parity(conf, data) ^ ($urandom_range(0, 3) == 0);
                tx(conf, data, par, $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);
            end
            check_state("rand_burst");
            while (model_q.size() > 0) pop_and_check("rand");
            check_state("rand_drained");
            if (model_ovr) begin
                pulse_clr();
                check_state("rand_clr");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
